// File: rtl/pcileech_ft601_pkg.sv
// Shared types and constants for the FT601 chip-side responder.
package pcileech_ft601_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } ft601_bus_state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } ft601_txent_t;

    localparam logic [3:0] FT601_BE_ALL = 4'hF;

endpackage

// File: rtl/pcileech_ft601_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module pcileech_ft601_resp_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;

    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/pcileech_ft601_resp.sv
// FT601 245-sync FIFO-mode device responder: serves FPGA reads from an RX FIFO,
// absorbs FPGA writes into a TX FIFO, and flags bus protocol violations.
//
// state | meaning
// IDLE  | bus released, waiting for oe_n or wr_n
// TURN  | bus turnaround, chip starts driving RX head
// READ  | chip drives data, rd_n pops words
// WRITE | FPGA write burst in progress
module pcileech_ft601_resp
    import pcileech_ft601_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 9,
    parameter int TX_DEPTH_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ft601_data_in,
    output logic [31:0] ft601_data_out,
    output logic        ft601_data_oe,
    input  logic [3:0]  ft601_be_in,
    output logic [3:0]  ft601_be_out,
    output logic        ft601_rxf_n,
    output logic        ft601_txe_n,
    input  logic        ft601_oe_n,
    input  logic        ft601_rd_n,
    input  logic        ft601_wr_n,
    input  logic [31:0] host_rx_din,
    input  logic        host_rx_wr_en,
    output logic        host_rx_full,
    output logic [35:0] host_tx_dout,
    output logic        host_tx_valid,
    input  logic        host_tx_rd_en,
    input  logic        stall_rx,
    input  logic        stall_tx,
    output logic [15:0] stat_drop_cnt,
    output logic        err_conflict,
    output logic        err_rd_no_oe
);
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};

    ft601_bus_state_t         state;
    ft601_bus_state_t         state_next;
    logic                     rx_empty;
    logic                     rx_full;
    logic                     tx_empty;
    logic                     tx_full;
    logic [RX_DEPTH_LOG2:0]   rx_count;
    logic [RX_DEPTH_LOG2:0]   rx_count_next;
    logic [TX_DEPTH_LOG2:0]   tx_count;
    logic [TX_DEPTH_LOG2:0]   tx_count_next;
    logic [31:0]              rx_head;
    logic [31:0]              data_hold;
    ft601_txent_t             tx_in;
    ft601_txent_t             tx_head;
    logic                     rx_push;
    logic                     rx_pop;
    logic                     tx_push;
    logic                     tx_pop;
    logic                     wr_drop;

    assign rx_push = host_rx_wr_en & ~rx_full;
    assign rx_pop  = ~ft601_rd_n & ~ft601_oe_n & ~ft601_rxf_n & ~rx_empty & (state == READ);
    // A write overlapping oe_n is a conflict: the read wins and the word is lost uncounted.
    assign tx_push = ~ft601_wr_n & ft601_oe_n & ~ft601_txe_n & ~tx_full;
    assign wr_drop = ~ft601_wr_n & ft601_oe_n & ft601_txe_n;
    assign tx_pop  = host_tx_rd_en & ~tx_empty;

    assign rx_count_next = rx_count + {{RX_DEPTH_LOG2{1'b0}}, rx_push}
                                    - {{RX_DEPTH_LOG2{1'b0}}, rx_pop};
    assign tx_count_next = tx_count + {{TX_DEPTH_LOG2{1'b0}}, tx_push}
                                    - {{TX_DEPTH_LOG2{1'b0}}, tx_pop};

    assign tx_in         = '{be: ft601_be_in, data: ft601_data_in};
    assign host_tx_dout  = tx_head;
    assign host_tx_valid = ~tx_empty;
    assign host_rx_full  = rx_full;

    pcileech_ft601_resp_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (rx_push),
        .din   (host_rx_din),
        .rd_en (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    pcileech_ft601_resp_fifo #(
        .WIDTH      (36),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (tx_push),
        .din   (tx_in),
        .rd_en (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Flags are registered from post-cycle occupancy, so txe_n is high before the FIFO can overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            stat_drop_cnt <= '0;
            err_conflict  <= 1'b0;
            err_rd_no_oe  <= 1'b0;
            data_hold     <= '0;
        end else begin
            ft601_rxf_n <= stall_rx | (rx_count_next == '0);
            ft601_txe_n <= stall_tx | (tx_count_next == TX_FULL_CNT);
            if (wr_drop && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if (~ft601_oe_n & ~ft601_wr_n)
                err_conflict <= 1'b1;
            if (~ft601_rd_n & ft601_oe_n)
                err_rd_no_oe <= 1'b1;
            data_hold <= ft601_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!ft601_oe_n)      state_next = TURN;
                else if (!ft601_wr_n) state_next = WRITE;
            end
            TURN:    state_next = ft601_oe_n ? IDLE : READ;
            READ:    if (ft601_oe_n) state_next = IDLE;
            WRITE:   if (ft601_wr_n) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // When the RX FIFO runs dry mid-read the bus keeps the last driven word.
    always_comb begin
        ft601_data_oe  = (state == TURN) || (state == READ);
        ft601_be_out   = ft601_data_oe ? FT601_BE_ALL : 4'h0;
        ft601_data_out = (ft601_data_oe && !rx_empty) ? rx_head : data_hold;
    end

endmodule
